// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-port Avalon bus arbiter.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Requester port indices.
    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin winner: a lone requester always wins,
// a tie goes to the port that did not win last time.
module rr_pick2
    import avalon_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Winner selection.
    always_comb begin
        grant_valid = |req;
        grant_idx   = PORT_IFETCH;
        unique case (req)
            2'b01:   grant_idx = PORT_IFETCH;
            2'b10:   grant_idx = PORT_DATA;
            2'b11:   grant_idx = ~last;
            default: grant_idx = PORT_IFETCH;
        endcase
    end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-requester Avalon-MM master arbiter: round-robin grant, latched request
// held on the bus until waitrequest drops, one-cycle done pulse, and a stall
// watchdog that aborts a transfer with an error.
module avalon_bus_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  be0,
    input  logic [3:0]  be1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic        owner,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT);

    arb_state_t        r_state, w_state_d;
    logic              r_owner, w_owner_d;
    logic              r_last,  w_last_d;
    logic              r_we,    w_we_d;
    logic [31:0]       r_addr,  w_addr_d;
    logic [31:0]       r_wdata, w_wdata_d;
    logic [3:0]        r_be,    w_be_d;
    logic [31:0]       r_rdata, w_rdata_d;
    logic              r_err,   w_err_d;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_d;

    logic              w_grant_valid;
    logic              w_grant_idx;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_in_bus;
    logic              w_in_resp;

    rr_pick2 u_rr_pick2 (
        .req         ({req1, req0}),
        .last        (r_last),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Next-state logic for the FSM and the latched request.
    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_last_d  = r_last;
        w_we_d    = r_we;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_be_d    = r_be;
        w_rdata_d = r_rdata;
        w_err_d   = r_err;
        w_cnt_d   = r_cnt;
        // Saturating increment so a disabled watchdog never wraps.
        w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_d = BUS;
                    w_owner_d = w_grant_idx;
                    w_last_d  = w_grant_idx;
                    w_we_d    = w_grant_idx ? we1    : we0;
                    w_addr_d  = w_grant_idx ? addr1  : addr0;
                    w_wdata_d = w_grant_idx ? wdata1 : wdata0;
                    w_be_d    = w_grant_idx ? be1    : be0;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_rdata_d = '0;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    w_rdata_d = r_we ? 32'h0 : readdata;
                    w_state_d = RESP;
                end else begin
                    w_cnt_d = w_cnt_inc;
                    if ((TIMEOUT != 0) && (w_cnt_inc == TIMEOUT_W)) begin
                        w_err_d   = 1'b1;
                        w_rdata_d = '0;
                        w_state_d = RESP;
                    end
                end
            end
            RESP: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State registers; strobes derive from r_state so reset drops them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= PORT_IFETCH;
            r_last  <= PORT_DATA;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
            r_last  <= w_last_d;
            r_we    <= w_we_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_be    <= w_be_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Bus and requester-side outputs decoded from the current state.
    always_comb begin
        w_in_bus   = (r_state == BUS);
        w_in_resp  = (r_state == RESP);
        busy       = (r_state != IDLE);
        owner      = r_owner;
        address    = w_in_bus ? r_addr  : 32'h0;
        writedata  = w_in_bus ? r_wdata : 32'h0;
        byteenable = w_in_bus ? r_be    : 4'h0;
        read       = w_in_bus & ~r_we;
        write      = w_in_bus &  r_we;
        done0      = w_in_resp & (r_owner == PORT_IFETCH);
        done1      = w_in_resp & (r_owner == PORT_DATA);
        err0       = done0 & r_err;
        err1       = done1 & r_err;
        rdata0     = done0 ? r_rdata : 32'h0;
        rdata1     = done1 ? r_rdata : 32'h0;
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter. A second instance with a short
// watchdog exercises the timeout path.
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic        waitrequest;
    logic [31:0] readdata;

    logic        done0, done1, err0, err1, busy, owner, read, write;
    logic [31:0] rdata0, rdata1, address, writedata;
    logic [3:0]  byteenable;

    logic        t_req0, t_wait;
    logic        t_done0, t_done1, t_err0, t_err1, t_busy, t_owner, t_read, t_write;
    logic [31:0] t_rdata0, t_rdata1, t_address, t_writedata;
    logic [3:0]  t_byteenable;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.TIMEOUT(255), .CNT_W(8)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy), .owner(owner),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    avalon_bus_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut_to (
        .clk(clk), .reset(rst_n),
        .req0(t_req0), .req1(1'b0), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1),
        .done0(t_done0), .done1(t_done1), .rdata0(t_rdata0), .rdata1(t_rdata1),
        .err0(t_err0), .err1(t_err1), .busy(t_busy), .owner(t_owner),
        .address(t_address), .read(t_read), .write(t_write),
        .writedata(t_writedata), .byteenable(t_byteenable),
        .waitrequest(t_wait), .readdata(readdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = 4'hF; be1 = 4'hF;
        waitrequest = 0; readdata = '0; t_req0 = 0; t_wait = 0;
        step();
        chk("rst_busy",  busy,  0);
        chk("rst_owner", owner, 0);
        chk("rst_read",  read,  0);
        chk("rst_write", write, 0);
        chk("rst_done",  {done1, done0}, 0);
        rst_n = 1'b1;
        step();

        // Single read.
        req0 = 1; we0 = 0; addr0 = 32'hBFC0_0000; readdata = 32'h2402_0005;
        step();
        chk("t1_read",  read, 1);
        chk("t1_write", write, 0);
        chk("t1_addr",  address, 32'hBFC0_0000);
        chk("t1_busy",  busy, 1);
        step();
        chk("t1_done0", done0, 1);
        chk("t1_rdata", rdata0, 32'h2402_0005);
        chk("t1_rd_off", read, 0);
        req0 = 0;
        step();
        chk("t1_idle",  busy, 0);
        chk("t1_done_clr", done0, 0);
        chk("t1_rdata_clr", rdata0, 0);

        // Stalled write from port 1.
        req1 = 1; we1 = 1; addr1 = 32'h0000_0080; wdata1 = 32'hDEAD_BEEF; be1 = 4'b0011;
        waitrequest = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_write", write, 1);
            chk("t3_read",  read, 0);
            chk("t3_addr",  address, 32'h0000_0080);
            chk("t3_wdata", writedata, 32'hDEAD_BEEF);
            chk("t3_be",    byteenable, 4'b0011);
            wdata1 = 32'h1111_1111 * (i + 1);
            step();
        end
        chk("t3_still", write, 1);
        chk("t3_nodone", done1, 0);
        waitrequest = 0;
        step();
        chk("t3_done1", done1, 1);
        chk("t3_err1",  err1, 0);
        chk("t3_rdata1", rdata1, 0);
        chk("t3_wr_off", write, 0);
        req1 = 0;
        step();

        // Contention: both held, grants alternate starting with port 0.
        we0 = 0; we1 = 0; addr0 = 32'h100; addr1 = 32'h200;
        req0 = 1; req1 = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_owner", owner, k % 2);
            chk("t2_addr",  address, (k % 2 == 0) ? 32'h100 : 32'h200);
            readdata = 32'hA000_0000 + k;
            step();
            chk("t2_done0", done0, (k % 2 == 0) ? 1 : 0);
            chk("t2_done1", done1, (k % 2 == 1) ? 1 : 0);
            chk("t2_rdata", (k % 2 == 0) ? rdata0 : rdata1, 32'hA000_0000 + k);
            step();
        end
        req0 = 0; req1 = 0;
        step();

        // Request inputs change after grant.
        req0 = 1; we0 = 0; addr0 = 32'h0000_1234; waitrequest = 1;
        step();
        addr0 = 32'hFFFF_0000;
        step();
        chk("t6_addr_a", address, 32'h0000_1234);
        step();
        chk("t6_addr_b", address, 32'h0000_1234);
        waitrequest = 0; readdata = 32'h55;
        step();
        chk("t6_done0", done0, 1);
        req0 = 0;
        step();

        // Reset in the middle of a stalled read.
        req0 = 1; addr0 = 32'h40; waitrequest = 1;
        step();
        chk("t5_read_pre", read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_read_rst", read, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_done_rst", done0, 0);
        step();
        rst_n = 1'b1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 1; waitrequest = 0;
        step();
        chk("t5_owner", owner, 0);
        chk("t5_read",  read, 1);
        chk("t5_write", write, 0);
        step();
        chk("t5_done0", done0, 1);
        req0 = 0; req1 = 0;
        step();

        // Watchdog abort on the short-timeout instance.
        t_req0 = 1; we0 = 0; addr0 = 32'h20; t_wait = 1; readdata = 32'hCAFE_F00D;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t4_read", t_read, 1);
            step();
        end
        chk("t4_rd_off", t_read, 0);
        chk("t4_done0", t_done0, 1);
        chk("t4_err0",  t_err0, 1);
        chk("t4_rdata", t_rdata0, 0);
        t_req0 = 0;
        step();
        chk("t4_err_clr", t_err0, 0);
        chk("t4_idle", t_busy, 0);
        t_req0 = 1; t_wait = 0; readdata = 32'h0BAD_CAFE;
        step();
        chk("t4_read2", t_read, 1);
        step();
        chk("t4_done2",  t_done0, 1);
        chk("t4_err2",   t_err0, 0);
        chk("t4_rdata2", t_rdata0, 32'h0BAD_CAFE);
        t_req0 = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
